unidade_controle_mc: RTL and testbench

Parametrised multicycle control FSM for the RV32I-subset core; successor to the fixed-latency controller. It adds variable-latency memory handshakes, full branch-condition evaluation (funct3 + ALU flags), LUI, an illegal-opcode trap, and cycle/retired-instruction counters. It sits between the instruction register and the datapath muxes, register file, PC register and memories.

---
 rtl/controle_pkg.sv | 47 ++++
 rtl/branch_cond.sv | 25 ++
 rtl/unidade_controle_mc.sv | 214 +++++++++++++++++++++
 tb/tb_unidade_controle_mc.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/controle_pkg.sv
// rtl/controle_pkg.sv - shared types and encodings for the multicycle control unit
package controle_pkg;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        EX_R      = 4'd2,
        EX_I      = 4'd3,
        EX_LOAD   = 4'd4,
        MEM_WAIT  = 4'd5,
        EX_STORE  = 4'd6,
        EX_BRANCH = 4'd7,
        EX_JAL    = 4'd8,
        EX_JALR   = 4'd9,
        EX_LUI    = 4'd10,
        EX_AUIPC  = 4'd11,
        WB        = 4'd12,
        NOP_PC    = 4'd13,
        TRAP      = 4'd14
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RF_ALU = 2'b00;
    localparam logic [1:0] RF_DM  = 2'b01;
    localparam logic [1:0] RF_PC4 = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_PASSB = 2'b11;

endpackage

// File: rtl/branch_cond.sv
// rtl/branch_cond.sv - branch taken/illegal decode from funct3 and ALU compare flags
module branch_cond (
    input  logic [2:0] funct3,
    input  logic       flag_zero,
    input  logic       flag_lt,
    input  logic       flag_ltu,
    output logic       taken,
    output logic       illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            3'b000:  taken = flag_zero;
            3'b001:  taken = ~flag_zero;
            3'b100:  taken = flag_lt;
            3'b101:  taken = ~flag_lt;
            3'b110:  taken = flag_ltu;
            3'b111:  taken = ~flag_ltu;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/unidade_controle_mc.sv
// rtl/unidade_controle_mc.sv - multicycle RV32I-subset control FSM with memory handshakes and counters
module unidade_controle_mc
    import controle_pkg::*;
#(
    parameter int MEM_HANDSHAKE   = 1,
    parameter int TRAP_ON_ILLEGAL = 1,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             flag_zero,
    input  logic             flag_lt,
    input  logic             flag_ltu,
    input  logic             im_ready,
    input  logic             dm_ready,
    output logic             re_IM,
    output logic             load_IR,
    output logic             load_PC,
    output logic             we_RF,
    output logic             re_DM,
    output logic             we_DM,
    output logic             sel_ALU_A,
    output logic             sel_ALU_B,
    output logic [1:0]       alu_op,
    output logic             sel_PC_A,
    output logic             sel_PC_B,
    output logic [2:0]       sel_imme,
    output logic [1:0]       sel_RF_in,
    output logic             illegal,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count
);

    state_t state, state_n;
    logic   wb_mem, wb_mem_n;
    logic   illegal_r;
    logic   br_taken, br_illegal;
    logic   im_ok, dm_ok;

    assign im_ok   = im_ready | (MEM_HANDSHAKE == 0);
    assign dm_ok   = dm_ready | (MEM_HANDSHAKE == 0);
    assign state_o = state;
    assign illegal = illegal_r;

    branch_cond u_branch_cond (
        .funct3    (funct3),
        .flag_zero (flag_zero),
        .flag_lt   (flag_lt),
        .flag_ltu  (flag_ltu),
        .taken     (br_taken),
        .illegal   (br_illegal)
    );

    always_comb begin
        state_n   = state;
        wb_mem_n  = wb_mem;
        re_IM     = 1'b0;
        load_IR   = 1'b0;
        load_PC   = 1'b0;
        we_RF     = 1'b0;
        re_DM     = 1'b0;
        we_DM     = 1'b0;
        sel_ALU_A = 1'b0;
        sel_ALU_B = 1'b0;
        alu_op    = ALU_ADD;
        sel_PC_A  = 1'b0;
        sel_PC_B  = 1'b0;
        sel_imme  = IMM_I;
        sel_RF_in = RF_ALU;
        case (state)
            FETCH: begin
                re_IM = 1'b1;
                if (im_ok) begin
                    load_IR = 1'b1;
                    state_n = DECODE;
                end
            end
            DECODE: begin
                case (opcode)
                    OP_R:      state_n = EX_R;
                    OP_I:      state_n = EX_I;
                    OP_LOAD:   state_n = EX_LOAD;
                    OP_STORE:  state_n = EX_STORE;
                    OP_BRANCH: state_n = EX_BRANCH;
                    OP_JAL:    state_n = EX_JAL;
                    OP_JALR:   state_n = EX_JALR;
                    OP_LUI:    state_n = EX_LUI;
                    OP_AUIPC:  state_n = EX_AUIPC;
                    default:   state_n = (TRAP_ON_ILLEGAL != 0) ? TRAP : NOP_PC;
                endcase
            end
            EX_R: begin
                alu_op   = ALU_FUNCT;
                wb_mem_n = 1'b0;
                state_n  = WB;
            end
            EX_I: begin
                sel_ALU_B = 1'b1;
                alu_op    = ALU_FUNCT;
                wb_mem_n  = 1'b0;
                state_n   = WB;
            end
            EX_LUI: begin
                sel_ALU_B = 1'b1;
                alu_op    = ALU_PASSB;
                sel_imme  = IMM_U;
                wb_mem_n  = 1'b0;
                state_n   = WB;
            end
            EX_AUIPC: begin
                sel_ALU_A = 1'b1;
                sel_ALU_B = 1'b1;
                sel_imme  = IMM_U;
                wb_mem_n  = 1'b0;
                state_n   = WB;
            end
            EX_LOAD, MEM_WAIT: begin
                // address stays driven until the data memory completes the read
                sel_ALU_B = 1'b1;
                re_DM     = 1'b1;
                if (state == EX_LOAD) begin
                    state_n = MEM_WAIT;
                end else if (dm_ok) begin
                    wb_mem_n = 1'b1;
                    state_n  = WB;
                end
            end
            WB: begin
                we_RF     = 1'b1;
                sel_RF_in = wb_mem ? RF_DM : RF_ALU;
                load_PC   = 1'b1;
                state_n   = FETCH;
            end
            EX_STORE: begin
                sel_ALU_B = 1'b1;
                sel_imme  = IMM_S;
                we_DM     = 1'b1;
                if (dm_ok) begin
                    load_PC = 1'b1;
                    state_n = FETCH;
                end
            end
            EX_BRANCH: begin
                alu_op   = ALU_SUB;
                sel_imme = IMM_B;
                if (br_illegal && (TRAP_ON_ILLEGAL != 0)) begin
                    state_n = TRAP;
                end else begin
                    load_PC  = 1'b1;
                    sel_PC_B = br_taken & ~br_illegal;
                    state_n  = FETCH;
                end
            end
            EX_JAL: begin
                sel_imme  = IMM_J;
                we_RF     = 1'b1;
                sel_RF_in = RF_PC4;
                load_PC   = 1'b1;
                sel_PC_B  = 1'b1;
                state_n   = FETCH;
            end
            EX_JALR: begin
                sel_imme  = IMM_I;
                we_RF     = 1'b1;
                sel_RF_in = RF_PC4;
                load_PC   = 1'b1;
                sel_PC_A  = 1'b1;
                sel_PC_B  = 1'b1;
                state_n   = FETCH;
            end
            NOP_PC: begin
                load_PC = 1'b1;
                state_n = FETCH;
            end
            TRAP: state_n = TRAP;
            default: state_n = TRAP;
        endcase
        // an access in flight is abandoned the moment reset rises
        if (rst) begin
            re_IM   = 1'b0;
            load_IR = 1'b0;
            load_PC = 1'b0;
            we_RF   = 1'b0;
            re_DM   = 1'b0;
            we_DM   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= FETCH;
            wb_mem        <= 1'b0;
            illegal_r     <= 1'b0;
            cycle_count   <= '0;
            instret_count <= '0;
        end else begin
            state  <= state_n;
            wb_mem <= wb_mem_n;
            if (state_n == TRAP) begin
                illegal_r <= 1'b1;
            end
            if (state != TRAP) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
            if (load_PC) begin
                instret_count <= instret_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_unidade_controle_mc.sv
// tb/tb_unidade_controle_mc.sv - scoreboard bench for unidade_controle_mc with a randomized instruction stream
module tb_unidade_controle_mc;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [6:0]    opcode = 7'd0;
    logic [2:0]    funct3 = 3'd0;
    logic          flag_zero = 1'b0, flag_lt = 1'b0, flag_ltu = 1'b0;
    logic          im_ready, dm_ready;
    logic          re_IM, load_IR, load_PC, we_RF, re_DM, we_DM;
    logic          sel_ALU_A, sel_ALU_B, sel_PC_A, sel_PC_B, illegal;
    logic [1:0]    alu_op, sel_RF_in;
    logic [2:0]    sel_imme;
    logic [3:0]    state_o;
    logic [CW-1:0] cycle_count, instret_count;

    unidade_controle_mc #(.MEM_HANDSHAKE(1), .TRAP_ON_ILLEGAL(1), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
        .flag_zero(flag_zero), .flag_lt(flag_lt), .flag_ltu(flag_ltu),
        .im_ready(im_ready), .dm_ready(dm_ready),
        .re_IM(re_IM), .load_IR(load_IR), .load_PC(load_PC), .we_RF(we_RF),
        .re_DM(re_DM), .we_DM(we_DM), .sel_ALU_A(sel_ALU_A), .sel_ALU_B(sel_ALU_B),
        .alu_op(alu_op), .sel_PC_A(sel_PC_A), .sel_PC_B(sel_PC_B), .sel_imme(sel_imme),
        .sel_RF_in(sel_RF_in), .illegal(illegal), .state_o(state_o),
        .cycle_count(cycle_count), .instret_count(instret_count)
    );

    always #5 clk = ~clk;

    // memories answer after a chosen number of strobed cycles
    int im_wait = 0, dm_wait = 0, im_cnt = 0, dm_cnt = 0;
    always @(posedge clk) begin
        if (rst || load_PC) begin
            im_cnt <= 0;
            dm_cnt <= 0;
        end else begin
            if (re_IM) im_cnt <= im_cnt + 1;
            if (re_DM || we_DM) dm_cnt <= dm_cnt + 1;
        end
    end
    assign im_ready = (im_cnt >= im_wait);
    assign dm_ready = (dm_cnt >= dm_wait);

    typedef struct {
        string name;
        int    trap;
        int    cycles;
        int    wr;
        int    rf_sel;
        int    pc_a;
        int    pc_b;
        int    n_re;
        int    n_we;
        int    cyc_cnt;
        int    ins_cnt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0, n_bad = 0;
    int   tot_cyc = 0, tot_ret = 0;

    function automatic void chk(string nm, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    initial begin : monitor
        int   cyc, n_re, n_we, saw_wr, rf_seen, in_trap, frz_cc, frz_ic;
        exp_t cur;
        cyc = 0; n_re = 0; n_we = 0; saw_wr = 0; rf_seen = 0; in_trap = 0;
        frz_cc = 0; frz_ic = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cyc = 0; n_re = 0; n_we = 0; saw_wr = 0; in_trap = 0;
                sb.delete();
            end else if (state_o == 4'd14) begin
                if (in_trap == 0) begin
                    in_trap = 1;
                    if (sb.size() == 0) begin
                        chk("unexpected_trap", 1, 0);
                    end else begin
                        cur = sb.pop_front();
                        chk({cur.name, "/trap"}, 1, cur.trap);
                        chk({cur.name, "/trap_cycles"}, cyc, cur.cycles);
                        frz_cc = cur.cyc_cnt;
                        frz_ic = cur.ins_cnt;
                    end
                end
                chk("trap/illegal", illegal, 1);
                chk("trap/cycle_frozen", cycle_count, frz_cc);
                chk("trap/instret_frozen", instret_count, frz_ic);
                chk("trap/strobes", {re_IM, load_IR, load_PC, we_RF, re_DM, we_DM}, 0);
            end else begin
                cyc++;
                if (re_DM) n_re++;
                if (we_DM) n_we++;
                if (we_RF) begin
                    saw_wr = 1;
                    rf_seen = sel_RF_in;
                end
                if (load_PC) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_retire", 1, 0);
                    end else begin
                        cur = sb.pop_front();
                        chk({cur.name, "/trap"}, 0, cur.trap);
                        chk({cur.name, "/cycles"}, cyc, cur.cycles);
                        chk({cur.name, "/we_RF"}, saw_wr, cur.wr);
                        if (cur.wr != 0) chk({cur.name, "/sel_RF_in"}, rf_seen, cur.rf_sel);
                        chk({cur.name, "/sel_PC_A"}, sel_PC_A, cur.pc_a);
                        chk({cur.name, "/sel_PC_B"}, sel_PC_B, cur.pc_b);
                        chk({cur.name, "/re_DM_cycles"}, n_re, cur.n_re);
                        chk({cur.name, "/we_DM_cycles"}, n_we, cur.n_we);
                        chk({cur.name, "/cycle_count"}, cycle_count, cur.cyc_cnt);
                        chk({cur.name, "/instret_count"}, instret_count, cur.ins_cnt);
                        chk({cur.name, "/illegal"}, illegal, 0);
                    end
                    cyc = 0; n_re = 0; n_we = 0; saw_wr = 0;
                end
            end
        end
    end

    // force_eq: -1 random operands, 0 distinct, 1 equal
    task automatic run_instr(input string nm, input logic [6:0] op, input logic [2:0] f3,
                             input int iw, input int dw, input int force_eq, input int abort_at);
        logic [31:0] a, b;
        exp_t        e;
        int          f, m, done;
        a = $urandom;
        b = $urandom;
        if (force_eq == 1 || (force_eq < 0 && $urandom_range(0, 3) == 0)) b = a;
        if (force_eq == 0 && a == b) b = a + 32'd1;
        flag_zero = (a == b);
        flag_lt   = ($signed(a) < $signed(b));
        flag_ltu  = (a < b);
        opcode = op;
        funct3 = f3;
        im_wait = iw;
        dm_wait = dw;
        e = '{name: nm, trap: 0, cycles: 0, wr: 0, rf_sel: 0, pc_a: 0, pc_b: 0,
              n_re: 0, n_we: 0, cyc_cnt: 0, ins_cnt: 0};
        f = iw + 1;
        m = (dw < 1) ? 1 : dw;
        case (op)
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: begin
                e.cycles = f + 3; e.wr = 1; e.rf_sel = 0;
            end
            7'b0000011: begin
                e.cycles = f + 3 + m; e.wr = 1; e.rf_sel = 1; e.n_re = 1 + m;
            end
            7'b0100011: begin
                e.cycles = f + 2 + dw; e.n_we = dw + 1;
            end
            7'b1100011: begin
                e.cycles = f + 2;
                case (f3)
                    3'd0: e.pc_b = int'(a == b);
                    3'd1: e.pc_b = int'(a != b);
                    3'd4: e.pc_b = int'($signed(a) < $signed(b));
                    3'd5: e.pc_b = int'($signed(a) >= $signed(b));
                    3'd6: e.pc_b = int'(a < b);
                    3'd7: e.pc_b = int'(a >= b);
                    default: e.trap = 1;
                endcase
            end
            7'b1101111: begin
                e.cycles = f + 2; e.wr = 1; e.rf_sel = 2; e.pc_b = 1;
            end
            7'b1100111: begin
                e.cycles = f + 2; e.wr = 1; e.rf_sel = 2; e.pc_a = 1; e.pc_b = 1;
            end
            default: begin
                e.trap = 1; e.cycles = f + 1;
            end
        endcase
        e.ins_cnt = tot_ret % (1 << CW);
        if (e.trap != 0) begin
            e.cyc_cnt = (tot_cyc + e.cycles) % (1 << CW);
        end else begin
            e.cyc_cnt = (tot_cyc + e.cycles - 1) % (1 << CW);
            tot_cyc += e.cycles;
            tot_ret++;
        end
        sb.push_back(e);
        done = 0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (abort_at > 0 && k == abort_at) return;
            if (load_PC || state_o == 4'd14) begin
                done = k;
                break;
            end
        end
        if (done == 0) chk({nm, "/timeout"}, 0, 1);
        if (state_o != 4'd14) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_and_check(input string nm);
        #2 rst = 1'b1;
        #1;
        chk({nm, "/state_o"}, state_o, 0);
        chk({nm, "/illegal"}, illegal, 0);
        chk({nm, "/cycle_count"}, cycle_count, 0);
        chk({nm, "/instret_count"}, instret_count, 0);
        chk({nm, "/strobes"}, {re_IM, load_IR, load_PC, we_RF, re_DM, we_DM}, 0);
        tot_cyc = 0;
        tot_ret = 0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    logic [6:0] ops [9];
    logic [2:0] bf3 [6];

    initial begin
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        bf3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        @(negedge clk);
        chk("reset/state_o", state_o, 0);
        chk("reset/illegal", illegal, 0);
        chk("reset/cycle_count", cycle_count, 0);
        chk("reset/instret_count", instret_count, 0);
        chk("reset/strobes", {re_IM, load_IR, load_PC, we_RF, re_DM, we_DM}, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        run_instr("add", 7'b0110011, 3'd0, 0, 0, -1, 0);
        run_instr("lw_wait3", 7'b0000011, 3'd2, 0, 3, -1, 0);
        run_instr("bne_taken", 7'b1100011, 3'd1, 0, 0, 0, 0);
        run_instr("bne_not_taken", 7'b1100011, 3'd1, 0, 0, 1, 0);
        run_instr("beq_taken", 7'b1100011, 3'd0, 1, 0, 1, 0);
        run_instr("sw_wait2", 7'b0100011, 3'd2, 2, 2, -1, 0);

        for (int i = 0; i < 60; i++) begin
            logic [6:0] op;
            logic [2:0] f3;
            op = ops[$urandom_range(0, 8)];
            f3 = (op == 7'b1100011) ? bf3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
            run_instr("rand", op, f3, $urandom_range(0, 2), $urandom_range(0, 3), -1, 0);
        end

        for (int i = 0; i < 17; i++) run_instr("jal_wrap", 7'b1101111, 3'd0, 0, 0, -1, 0);

        run_instr("bad_opcode", 7'b0000000, 3'd0, 1, 0, -1, 0);
        repeat (10) @(negedge clk);
        reset_and_check("trap_reset");

        run_instr("after_trap_lui", 7'b0110111, 3'd0, 0, 0, -1, 0);
        run_instr("bad_branch_f3", 7'b1100011, 3'd2, 0, 0, -1, 0);
        repeat (3) @(negedge clk);
        reset_and_check("branch_trap_reset");

        run_instr("lw_abort", 7'b0000011, 3'd2, 0, 8, -1, 5);
        chk("abort/in_mem_wait", state_o, 5);
        chk("abort/re_DM_before", re_DM, 1);
        reset_and_check("abort_reset");

        for (int i = 0; i < 10; i++) begin
            run_instr("rand_tail", ops[$urandom_range(0, 8)], 3'd0, $urandom_range(0, 1),
                      $urandom_range(0, 2), -1, 0);
        end
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule
